// File: rtl/ray_job_dispatcher.sv
// Row-level job dispatcher for the raytracing worker bank: precomputes per-row y-terms,
// launches the workers, waits for them to drain and hands each finished row downstream.
// Optional RUN watchdog is compiled in with `define RAY_DISPATCH_WATCHDOG_EN.

package Types;
  typedef struct packed {
    logic signed [13:0] x;
    logic signed [13:0] y;
    logic signed [13:0] z;
    logic        [13:0] r;
  } Sphere;
endpackage

module ray_job_dispatcher #(
  parameter int unsigned N_WORKERS        = 16,
  parameter int unsigned JOBS_SUBDIVISION = 40,
  parameter int unsigned X_HALF           = 320,
  parameter int unsigned Y_HALF           = 240,
  parameter int unsigned WATCHDOG_CYCLES  = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  Types::Sphere         sphere_in,
  input  logic [N_WORKERS-1:0] worker_busy,
  output Types::Sphere         sphere,
  output logic signed [11:0]   pixel_start_x [N_WORKERS],
  output logic signed [21:0]   doty_r,
  output logic        [15:0]   pixely_sr,
  output logic        [26:0]   originy_sr,
  output logic                 activate,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic        [8:0]    row_idx,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 watchdog_err
);

  if (N_WORKERS * JOBS_SUBDIVISION != 2 * X_HALF) begin : g_row_width_check
    $error("N_WORKERS*JOBS_SUBDIVISION must equal the row width 2*X_HALF");
  end
  if (WATCHDOG_CYCLES == 0) begin : g_watchdog_check
    $error("WATCHDOG_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StPrep1,
    StPrep2,
    StLaunch,
    StRun,
    StHandoff,
    StNext
  } state_e;

  state_e             state_q, state_d;
  Types::Sphere       sphere_q, sphere_d;
  logic        [8:0]  row_idx_q, row_idx_d;
  logic signed [9:0]  pixel_y_q, pixel_y_d;
  logic        [15:0] pixely_sr_q, pixely_sr_d;
  logic signed [21:0] doty_r_q, doty_r_d;
  logic        [26:0] originy_sr_q, originy_sr_d;
  logic               launch_cnt_q, launch_cnt_d;
  logic               frame_busy_q, frame_busy_d;
  logic               last_row;
  logic               wd_timeout;

  assign last_row = (row_idx_q == 9'(2 * Y_HALF - 1));

  // Start columns are fixed by worker position, so they never touch a flop.
  for (genvar w = 0; w < N_WORKERS; w++) begin : g_start_x
    assign pixel_start_x[w] = 12'(int'(w) - int'(X_HALF));
  end

`ifdef RAY_DISPATCH_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           watchdog_err_q, watchdog_err_d;

  // Counter is 0 on the first RUN cycle, so timeout fires on RUN cycle WATCHDOG_CYCLES.
  always_comb begin
    wd_cnt_d       = (state_q == StRun) ? wd_cnt_q + WdW'(1) : '0;
    wd_timeout     = (state_q == StRun) && (worker_busy != '0) &&
                     (wd_cnt_q == WdW'(WATCHDOG_CYCLES - 1));
    watchdog_err_d = watchdog_err_q | wd_timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q       <= '0;
      watchdog_err_q <= 1'b0;
    end else begin
      wd_cnt_q       <= wd_cnt_d;
      watchdog_err_q <= watchdog_err_d;
    end
  end

  assign watchdog_err = watchdog_err_q;
`else
  assign wd_timeout   = 1'b0;
  assign watchdog_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_start) state_d = StPrep1;
      StPrep1:   state_d = StPrep2;
      StPrep2:   state_d = StLaunch;
      StLaunch:  if (launch_cnt_q) state_d = StRun;
      StRun:     if ((worker_busy == '0) || wd_timeout) state_d = StHandoff;
      StHandoff: if (row_ready) state_d = StNext;
      StNext:    state_d = last_row ? StIdle : StPrep1;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    activate   = (state_q == StLaunch) || (state_q == StRun);
    row_valid  = (state_q == StHandoff);
    frame_done = (state_q == StNext) && last_row;
  end

  // Row datapath next-state.
  always_comb begin
    sphere_d     = sphere_q;
    row_idx_d    = row_idx_q;
    pixel_y_d    = pixel_y_q;
    pixely_sr_d  = pixely_sr_q;
    doty_r_d     = doty_r_q;
    originy_sr_d = originy_sr_q;
    launch_cnt_d = 1'b0;
    frame_busy_d = frame_busy_q;

    if ((state_q == StIdle) && frame_start) begin
      sphere_d     = sphere_in;
      row_idx_d    = '0;
      frame_busy_d = 1'b1;
    end

    if (state_q == StPrep1) begin
      pixel_y_d = $signed({1'b0, row_idx_q}) - $signed(10'(Y_HALF));
    end

    // Operands are sign-extended to the result width first, so the low bits are exact.
    if (state_q == StPrep2) begin
      pixely_sr_d  = 16'(16'(pixel_y_q) * 16'(pixel_y_q));
      doty_r_d     = 22'(pixel_y_q) * 22'(sphere_q.y);
      originy_sr_d = 27'(27'(sphere_q.y) * 27'(sphere_q.y));
    end

    // Holds activate for two cycles so workers have raised busy before RUN samples it.
    if (state_q == StLaunch) begin
      launch_cnt_d = ~launch_cnt_q;
    end

    if (state_q == StNext) begin
      if (last_row) begin
        frame_busy_d = 1'b0;
      end else begin
        row_idx_d = row_idx_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sphere_q     <= '0;
      row_idx_q    <= '0;
      pixel_y_q    <= '0;
      pixely_sr_q  <= '0;
      doty_r_q     <= '0;
      originy_sr_q <= '0;
      launch_cnt_q <= 1'b0;
      frame_busy_q <= 1'b0;
    end else begin
      sphere_q     <= sphere_d;
      row_idx_q    <= row_idx_d;
      pixel_y_q    <= pixel_y_d;
      pixely_sr_q  <= pixely_sr_d;
      doty_r_q     <= doty_r_d;
      originy_sr_q <= originy_sr_d;
      launch_cnt_q <= launch_cnt_d;
      frame_busy_q <= frame_busy_d;
    end
  end

  assign sphere     = sphere_q;
  assign row_idx    = row_idx_q;
  assign doty_r     = doty_r_q;
  assign pixely_sr  = pixely_sr_q;
  assign originy_sr = originy_sr_q;
  assign frame_busy = frame_busy_q;

endmodule

// File: tb/tb_ray_job_dispatcher.sv
// Directed bench for ray_job_dispatcher: a full-size instance (short watchdog) for row terms,
// handshake, reset and watchdog, plus a 4-row instance for whole-frame sequencing.

module tb_ray_job_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  Types::Sphere sphere_in;

  // Full-size instance.
  logic               frame_start, row_ready;
  logic [15:0]        worker_busy;
  Types::Sphere       sphere;
  logic signed [11:0] pixel_start_x [16];
  logic signed [21:0] doty_r;
  logic [15:0]        pixely_sr;
  logic [26:0]        originy_sr;
  logic               activate, row_valid, frame_busy, frame_done, watchdog_err;
  logic [8:0]         row_idx;

  // Four-row instance.
  logic               fs_b, ready_b;
  logic [15:0]        busy_b;
  Types::Sphere       sphere_b;
  logic signed [11:0] psx_b [16];
  logic signed [21:0] doty_b;
  logic [15:0]        pixely_b;
  logic [26:0]        originy_b;
  logic               act_b, valid_b, fbusy_b, fdone_b, wderr_b;
  logic [8:0]         row_idx_b;

  ray_job_dispatcher #(
    .WATCHDOG_CYCLES(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .sphere_in    (sphere_in),
    .worker_busy  (worker_busy),
    .sphere       (sphere),
    .pixel_start_x(pixel_start_x),
    .doty_r       (doty_r),
    .pixely_sr    (pixely_sr),
    .originy_sr   (originy_sr),
    .activate     (activate),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_idx      (row_idx),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .watchdog_err (watchdog_err)
  );

  ray_job_dispatcher #(
    .Y_HALF(2)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (fs_b),
    .sphere_in    (sphere_in),
    .worker_busy  (busy_b),
    .sphere       (sphere_b),
    .pixel_start_x(psx_b),
    .doty_r       (doty_b),
    .pixely_sr    (pixely_b),
    .originy_sr   (originy_b),
    .activate     (act_b),
    .row_valid    (valid_b),
    .row_ready    (ready_b),
    .row_idx      (row_idx_b),
    .frame_busy   (fbusy_b),
    .frame_done   (fdone_b),
    .watchdog_err (wderr_b)
  );

  int checks = 0;
  int errors = 0;
  int bad, n_valid, n_hand, n_done;
  int exp_py [4]   = '{4, 1, 0, 1};
  int exp_doty [4] = '{-200, -100, 0, 100};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    worker_busy = '0;
    row_ready   = 1'b0;
    sphere_in   = '0;
    fs_b        = 1'b0;
    busy_b      = '0;
    ready_b     = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values.
    check("rst_activate", activate, 0);
    check("rst_row_valid", row_valid, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_watchdog_err", watchdog_err, 0);
    check("rst_doty", doty_r, 0);
    check("rst_pixely", pixely_sr, 0);
    check("rst_originy", originy_sr, 0);
    check("rst_sphere_y", sphere.y, 0);
    check("rst_sphere_x", sphere.x, 0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (activate || row_valid || frame_busy || frame_done) bad++;
    end
    check("idle_quiet", bad, 0);

    // Row 0 of a frame with sphere.y = 100.
    sphere_in   = '{x: 14'sd5, y: 14'sd100, z: 14'sd300, r: 14'd50};
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    sphere_in   = '0;
    check("start_frame_busy", frame_busy, 1);
    check("start_row_idx", row_idx, 0);
    check("prep1_activate", activate, 0);
    check("latched_sphere_y", sphere.y, 100);
    check("latched_sphere_z", sphere.z, 300);
    tick();
    check("prep2_activate", activate, 0);
    tick();
    check("launch_activate", activate, 1);
    check("row0_pixely", pixely_sr, 57600);
    check("row0_doty", doty_r, -24000);
    check("row0_originy", originy_sr, 10000);
    check("start_x_w0", pixel_start_x[0], -320);
    check("start_x_w3", pixel_start_x[3], -317);
    check("start_x_w15", pixel_start_x[15], -305);
    worker_busy = '1;
    tick();
    check("launch2_activate", activate, 1);
    tick();
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      if (!activate || row_valid) bad++;
      tick();
    end
    check("run_hold", bad, 0);
    check("stable_sphere_y", sphere.y, 100);
    check("stable_doty", doty_r, -24000);

    // Handoff with row_ready delayed 7 cycles.
    worker_busy = '0;
    tick();
    n_valid = 0;
    bad     = 0;
    for (int i = 0; i < 7; i++) begin
      if (row_valid) n_valid++;
      if (activate) bad++;
      if (i == 6) row_ready = 1'b1;
      tick();
    end
    row_ready = 1'b0;
    check("handoff_valid_cycles", n_valid, 7);
    check("handoff_activate_low", bad, 0);
    check("next_row_valid", row_valid, 0);
    check("next_frame_done", frame_done, 0);
    tick();
    check("row1_row_idx", row_idx, 1);
    tick();
    tick();
    check("row1_activate", activate, 1);
    check("row1_pixely", pixely_sr, 57121);
    check("row1_doty", doty_r, -23900);

    // Reset in the middle of row 1's RUN.
    worker_busy = '1;
    tick();
    tick();
    tick();
    check("row1_running", activate, 1);
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    worker_busy = '0;
    check("midrst_activate", activate, 0);
    check("midrst_row_idx", row_idx, 0);
    check("midrst_frame_busy", frame_busy, 0);
    check("midrst_pixely", pixely_sr, 0);
    check("midrst_sphere_y", sphere.y, 0);
    tick();
    check("midrst_idle", activate, 0);

    // Worker 5 stuck busy.
    sphere_in   = '{x: 14'sd5, y: 14'sd100, z: 14'sd300, r: 14'd50};
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    worker_busy = 16'h0020;
    tick();
    tick();
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!activate || row_valid || watchdog_err) bad++;
      tick();
    end
    check("wd_run_window", bad, 0);
`ifdef RAY_DISPATCH_WATCHDOG_EN
    check("wd_handoff_valid", row_valid, 1);
    check("wd_err_set", watchdog_err, 1);
    check("wd_activate_low", activate, 0);
`else
    check("nowd_still_run", row_valid, 0);
    check("nowd_err_low", watchdog_err, 0);
    check("nowd_activate", activate, 1);
`endif
    worker_busy = '0;
    row_ready   = 1'b1;
    tick();
    tick();
    row_ready = 1'b0;
`ifdef RAY_DISPATCH_WATCHDOG_EN
    check("wd_err_sticky", watchdog_err, 1);
`else
    check("nowd_err_sticky", watchdog_err, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_err_cleared", watchdog_err, 0);

    // Whole 4-row frame; a second frame_start during row 1 must be dropped.
    fs_b = 1'b1;
    tick();
    fs_b   = 1'b0;
    n_hand = 0;
    n_done = 0;
    for (int r = 0; r < 4; r++) begin
      tick();
      tick();
      check($sformatf("frame_row%0d_idx", r), row_idx_b, r);
      check($sformatf("frame_row%0d_pixely", r), pixely_b, exp_py[r]);
      check($sformatf("frame_row%0d_doty", r), doty_b, exp_doty[r]);
      busy_b = '1;
      tick();
      tick();
      if (r == 1) fs_b = 1'b1;
      tick();
      fs_b    = 1'b0;
      busy_b  = '0;
      ready_b = 1'b1;
      tick();
      if (valid_b) n_hand++;
      if (fdone_b) n_done++;
      tick();
      ready_b = 1'b0;
      if (valid_b) n_hand++;
      if (fdone_b) n_done++;
      check($sformatf("frame_row%0d_done", r), fdone_b, (r == 3) ? 1 : 0);
      check($sformatf("frame_row%0d_busy", r), fbusy_b, 1);
      tick();
    end
    check("frame_handoffs", n_hand, 4);
    check("frame_done_pulses", n_done, 1);
    check("frame_end_busy", fbusy_b, 0);
    check("frame_end_done", fdone_b, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (act_b || fbusy_b || fdone_b) bad++;
      tick();
    end
    check("frame_start_not_queued", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
